// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_logic_unit
// Description : Registered bitwise logic unit with a valid/ready input side
//               and a 2-entry in-order output buffer.
//               The result is computed when an operation is accepted.
//               It appears on out one cycle later at the earliest.
//
//               op : 000 ~x, 001 x&y, 010 x|y, 011 x^y,
//                    100 ~(x&y), 101 ~(x|y), 110 ~(x^y), 111 x
//
//               Optional build macro BITWISE_LOGIC_UNIT_FLAGS_EN adds the
//               out_zero and out_neg outputs. These are stored per buffer
//               entry and stay aligned with out.
//
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               x, y       - operands (y unused by unary ops)
//               op         - operation select
//               in_valid   - operation present     in_ready  - can accept
//               out        - head result           out_valid - head valid
//               out_ready  - consumer takes head
//               out_zero   - head result == 0      (flags build only)
//               out_neg    - head result MSB       (flags build only)
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    localparam logic [2:0] c_op_not  = 3'b000;
    localparam logic [2:0] c_op_and  = 3'b001;
    localparam logic [2:0] c_op_or   = 3'b010;
    localparam logic [2:0] c_op_xor  = 3'b011;
    localparam logic [2:0] c_op_nand = 3'b100;
    localparam logic [2:0] c_op_nor  = 3'b101;
    localparam logic [2:0] c_op_xnor = 3'b110;

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    localparam int c_flag_w = 2;
`else
    localparam int c_flag_w = 0;
`endif
    localparam int c_entry_w = WIDTH + c_flag_w;

    // Buffer entry layout: {neg, zero, result} or just {result}.
    logic [c_entry_w-1:0] r_head;
    logic [c_entry_w-1:0] r_tail;
    logic [1:0]           r_count;

    logic [WIDTH-1:0]     w_res;
    logic [c_entry_w-1:0] w_entry;
    logic                 w_accept;
    logic                 w_pop;

    always_comb begin
        w_res = x;
        case (op)
            c_op_not:  w_res = ~x;
            c_op_and:  w_res = x & y;
            c_op_or:   w_res = x | y;
            c_op_xor:  w_res = x ^ y;
            c_op_nand: w_res = ~(x & y);
            c_op_nor:  w_res = ~(x | y);
            c_op_xnor: w_res = ~(x ^ y);
            default:   w_res = x;
        endcase
    end

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    assign w_entry  = {w_res[WIDTH-1], (w_res == '0), w_res};
    assign out_zero = r_head[WIDTH];
    assign out_neg  = r_head[WIDTH+1];
`else
    assign w_entry  = w_res;
`endif

    // Both handshake outputs come straight from registered count, so there
    // is no combinational path from out_ready back to in_ready.
    assign in_ready  = ~r_count[1];
    assign out_valid = |r_count;
    assign out       = r_head[WIDTH-1:0];

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_accept) begin
                        r_head  <= w_entry;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_accept && w_pop) begin
                        // Head leaves and the new result takes its place.
                        r_head <= w_entry;
                    end else if (w_accept) begin
                        r_tail  <= w_entry;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: no accept is possible, only a pop shifts tail up.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_logic_unit
// Description : Scoreboard bench for bitwise_logic_unit (WIDTH = 16).
//               Expected results are queued on accept.
//               They are popped and compared when the unit delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] x, y;
    logic [2:0]  op;
    logic        in_valid, in_ready;
    logic [15:0] out;
    logic        out_valid, out_ready;
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    logic        out_zero, out_neg;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_neg   (out_neg)
`endif
    );

    function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            3'b000:  return ~a;
            3'b001:  return a & b;
            3'b010:  return a | b;
            3'b011:  return a ^ b;
            3'b100:  return ~(a & b);
            3'b101:  return ~(a | b);
            3'b110:  return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; op = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out got=%h exp=0000", out); end
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
        n_vec++; if ({out_zero, out_neg} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b exp=00", {out_zero, out_neg}); end
`endif
        rst_n = 1'b1;
    endtask

    // First accept on the first edge after reset release.
    task automatic test_single;
        in_valid = 1'b1; op = 3'b000; x = 16'h00FF; y = 16'h0000; out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
        if (in_valid && in_ready) sb.push_back(model(op, x, y));
        next_cycle;
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        n_vec++; if (out !== 16'hFF00) begin n_err++; $display("FAIL single_out got=%h exp=ff00", out); end
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
        n_vec++; if ({out_zero, out_neg} !== 2'b01) begin n_err++; $display("FAIL single_flags zero/neg got=%b exp=01", {out_zero, out_neg}); end
`endif
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        next_cycle;
    endtask

    task automatic test_op_sweep;
        logic [15:0] c_sweep [8];
        c_sweep = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
        x = 16'hF0F0; y = 16'hFF00; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 8);
            op = 3'(i);
            #1;
            if (i >= 1) begin
                n_vec++;
                if (out_valid !== 1'b1 || out !== c_sweep[i-1])
                begin n_err++; $display("FAIL sweep_op%0d got=%h/%b exp=%h/1", i-1, out, out_valid, c_sweep[i-1]); end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL sweep_sb unexpected out=%h", out); end
                else begin
                    exp_v = sb.pop_front();
                    if (out !== exp_v) begin n_err++; $display("FAIL sweep_sb got=%h exp=%h", out, exp_v); end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(op, x, y));
            next_cycle;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [3];
        int k;
        ops = '{3'b001, 3'b010, 3'b011};
        k = 0;
        x = 16'hA5C3; y = 16'h0FF0;
        for (int c = 0; c < 7; c++) begin
            in_valid  = (k < 3);
            op        = ops[(k < 3) ? k : 2];
            out_ready = (c >= 3);
            #1;
            if (c == 2) begin
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_in_ready got=%b exp=0", in_ready); end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL b2b_sb unexpected out=%h", out); end
                else begin
                    exp_v = sb.pop_front();
                    if (out !== exp_v) begin n_err++; $display("FAIL b2b_sb got=%h exp=%h", out, exp_v); end
                end
            end
            if (in_valid && in_ready) begin sb.push_back(model(op, x, y)); k++; end
            next_cycle;
        end
        n_vec++;
        if (sb.size() != 0 || k != 3) begin n_err++; $display("FAIL b2b_drain left=%0d accepted=%0d exp=0/3", sb.size(), k); end
        in_valid = 1'b0;
    endtask

    task automatic test_throughput;
        in_valid = 1'b1; out_ready = 1'b0; op = 3'b100; x = 16'h1357; y = 16'hFFFF;
        #1;
        if (in_valid && in_ready) sb.push_back(model(op, x, y));
        next_cycle;
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 10);
            op = 3'(c); x = 16'(c * 16'h1111); y = 16'h0F0F;
            #1;
            if (c < 10) begin
                n_vec++;
                if (in_ready !== 1'b1 || out_valid !== 1'b1)
                begin n_err++; $display("FAIL thru_cyc%0d ready/valid got=%b%b exp=11", c, in_ready, out_valid); end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL thru_sb unexpected out=%h", out); end
                else begin
                    exp_v = sb.pop_front();
                    if (out !== exp_v) begin n_err++; $display("FAIL thru_sb got=%h exp=%h", out, exp_v); end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(op, x, y));
            next_cycle;
        end
        in_valid = 1'b0;
    endtask

    // Fill both entries, reset, and ensure nothing buffered ever appears.
    task automatic test_reset_mid;
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b111;
        for (int c = 0; c < 2; c++) begin
            x = 16'hBEE0 + 16'(c);
            next_cycle;
        end
        rst_n = 1'b0; out_ready = 1'b1; x = 16'hDEAD;
        next_cycle;
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out !== 16'h0000) begin n_err++; $display("FAIL rstmid_out got=%h exp=0000", out); end
        sb.delete();
        for (int c = 0; c < 3; c++) begin
            next_cycle;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_ghost cyc%0d out=%h", c, out); end
        end
    endtask

    task automatic test_flags;
        in_valid = 1'b1; op = 3'b011; x = 16'h1234; y = 16'h1234; out_ready = 1'b1;
        #1;
        if (in_valid && in_ready) sb.push_back(model(op, x, y));
        next_cycle;
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1 || out !== 16'h0000) begin n_err++; $display("FAIL xor_self got=%h/%b exp=0000/1", out, out_valid); end
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
        n_vec++; if ({out_zero, out_neg} !== 2'b10) begin n_err++; $display("FAIL xor_self_flags got=%b exp=10", {out_zero, out_neg}); end
`endif
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        next_cycle;
    endtask

    task automatic test_random;
        int          acc = 0;
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_out = '0;
        while ((acc < 10000 || sb.size() != 0) && cyc < 60000) begin
            in_valid  = (acc < 10000) && ($urandom_range(0, 9) < 7);
            out_ready = (acc >= 10000) || ($urandom_range(0, 9) < 6);
            op = 3'($urandom_range(0, 7));
            x  = 16'($urandom);
            y  = 16'($urandom);
            #1;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out !== prev_out)
                begin n_err++; $display("FAIL rand_stall cyc%0d got=%h/%b exp=%h/1", cyc, out, out_valid, prev_out); end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL rand_sb unexpected out=%h", out); end
                else begin
                    exp_v = sb.pop_front();
                    if (out !== exp_v) begin n_err++; $display("FAIL rand_sb cyc%0d got=%h exp=%h", cyc, out, exp_v); end
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
                    if ({out_zero, out_neg} !== {(exp_v == 16'h0), exp_v[15]})
                    begin n_err++; $display("FAIL rand_flags got=%b exp=%b", {out_zero, out_neg}, {(exp_v == 16'h0), exp_v[15]}); end
`endif
                end
            end
            if (in_valid && in_ready) begin sb.push_back(model(op, x, y)); acc++; end
            next_cycle;
            cyc++;
        end
        n_vec++;
        if (acc != 10000 || sb.size() != 0) begin n_err++; $display("FAIL rand_done accepted=%0d left=%0d exp=10000/0", acc, sb.size()); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_op_sweep;
        test_back_to_back;
        test_throughput;
        test_reset_mid;
        test_flags;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 1..64.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 x  input  WIDTH  operand A.
REQ-005 y  input  WIDTH  operand B; ignored by unary ops.
REQ-006 op  input  3  operation select, encoded per REQ-012.
REQ-007 in_valid  input  1  x/y/op are valid this cycle.
REQ-008 in_ready  output  1  block accepts an operation this cycle.
REQ-009 out  output  WIDTH  result at head of output buffer.
REQ-010 out_valid  output  1  out holds a valid result.
REQ-011 out_ready  input  1  consumer takes out this cycle.

Function
REQ-012 op encoding, bitwise on all WIDTH bits: 000 ~x; 001 x&y; 010 x|y; 011 x^y; 100 ~(x&y); 101 ~(x|y); 110 ~(x^y); 111 x (pass).
REQ-013 Accept occurs when in_valid && in_ready on a rising edge; pop occurs when out_valid && out_ready on a rising edge.
REQ-014 Result is computed at accept and written to a 2-entry in-order output buffer; minimum latency is 1 cycle from accept to out_valid.
REQ-015 Buffer occupancy count is 0, 1 or 2; out/out_valid always reflect the oldest entry; out_valid = (count != 0).
REQ-016 in_ready = (count < 2), driven from registered state only; no combinational path from out_ready to in_ready.
REQ-017 Simultaneous accept and pop with count 1: count stays 1, popped entry replaced by the new result on the same edge.
REQ-018 Simultaneous accept and pop with count 0 is impossible (no pop when out_valid low); accept alone gives count 1.
REQ-019 Pop with count 2: older entry leaves, newer entry becomes head on the next cycle, count 1.
REQ-020 in_valid while in_ready low: input ignored, no state change; upstream holds it.
REQ-021 out and any flags hold stable while out_valid && !out_ready.
REQ-022 Results leave in acceptance order; no drop, duplication or reordering for any valid/ready pattern.
REQ-023 op values are all legal; no X propagation for any 3-bit op.

Reset
REQ-024 While rst_n low at a rising edge: count := 0, out_valid := 0, in_ready := 1 after the edge, out := 0, flags := 0.
REQ-025 Reset mid-operation discards all buffered results; accepts and pops in the reset cycle are ignored.
REQ-026 First accept is possible on the first rising edge with rst_n high.

Configuration
REQ-027 Macro BITWISE_LOGIC_UNIT_FLAGS_EN controls result-flag outputs.
REQ-028 Defined: outputs out_zero (1 bit, result == 0) and out_neg (1 bit, result MSB) are present, stored per buffer entry and aligned with out.
REQ-029 Undefined: out_zero and out_neg ports and their storage are absent; all other behaviour identical.

Verification (WIDTH=16)
REQ-030 Reset, then op=000, x=16'h00FF, in_valid=1, out_ready=1 -> next cycle out=16'hFF00, out_valid=1; flags build: out_zero=0, out_neg=1.
REQ-031 Sweep op 000..111 with x=16'hF0F0, y=16'hFF00, out_ready=1 -> out sequence 0F0F, F000, FFF0, 0FF0, 0FFF, 000F, F00F, F0F0, one per cycle, in order.
REQ-032 out_ready=0, three back-to-back accepts -> first two accepted, in_ready low from the cycle after the 2nd accept, 3rd held; raise out_ready -> all three emerge in order.
REQ-033 count=1, simultaneous accept and pop every cycle for 10 cycles -> continuous throughput of 1 result/cycle, in_ready stays 1, count stays 1.
REQ-034 count=2, assert rst_n=0 for one cycle -> out_valid=0, in_ready=1, out=0 after the edge; buffered results never appear.
REQ-035 Flags build: op=011, x=y=16'h1234 -> out=0, out_zero=1, out_neg=0; random valid/ready run of 10k ops matches a reference queue model.
